adc_conv_scheduler: RTL



---
 rtl/adc_conv_scheduler.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/adc_conv_scheduler.sv
// adc_conv_scheduler: shares one SAR ADC between NREQ requesters.
// Round-robin arbitration, registered config words, a clean start pulse,
// a synchronized finish with timeout, and a per-requester done/timeout pulse.
//
// Handshake: a requester raises req_i[k] and holds it. When granted, gnt_o[k]
// stays high for the whole transaction. The transaction ends with a one-cycle
// done_o[k] (result_o valid in that cycle) or timeout_o[k] (result_o unchanged).
// req_i[k] still high after that pulse counts as a new request.
module adc_conv_scheduler #(
    parameter int NREQ           = 4,
    parameter int SETTLE_CYCLES  = 2,
    parameter int START_CYCLES   = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable_i,
    input  logic [NREQ-1:0]      req_i,
    input  logic [16*NREQ-1:0]   req_config_1_i,
    input  logic [16*NREQ-1:0]   req_config_2_i,
    output logic [NREQ-1:0]      gnt_o,
    output logic [NREQ-1:0]      done_o,
    output logic [NREQ-1:0]      timeout_o,
    output logic [15:0]          result_o,
    output logic                 busy_o,
    output logic                 adc_start_conversion_o,
    output logic [15:0]          adc_config_1_o,
    output logic [15:0]          adc_config_2_o,
    input  logic [15:0]          adc_result_i,
    input  logic                 adc_conversion_finished_i
);

    localparam int IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, START, WAIT, DONE} state_t;

    state_t            state_q, state_d;
    logic [IDXW-1:0]   last_grant_q;
    logic [IDXW-1:0]   gidx_q;
    logic [IDXW-1:0]   win_idx;
    logic [IDXW-1:0]   cand;
    logic              win_found;
    logic [NREQ-1:0]   gnt_q;
    logic [15:0]       cnt_q;
    logic              ok_q;
    logic [15:0]       result_q;
    logic [15:0]       cfg1_q, cfg2_q;
    logic              start_q;
    logic              fin_s1_q, fin_s2_q, fin_hist_q;
    logic              fin_rise;
    logic              timed_out;
    logic [15:0]       cfg1_arr [NREQ];
    logic [15:0]       cfg2_arr [NREQ];

    // Unpack the per-requester config words so the winner can be indexed.
    for (genvar k = 0; k < NREQ; k++) begin : g_cfg
        assign cfg1_arr[k] = req_config_1_i[16*k +: 16];
        assign cfg2_arr[k] = req_config_2_i[16*k +: 16];
    end

    // Round-robin search starting just after the last served requester.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDXW'((int'(last_grant_q) + i) % NREQ);
            if (!win_found && req_i[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Only a rising edge of the synchronized finish counts, and only in WAIT.
    assign fin_rise  = fin_s2_q & ~fin_hist_q & (state_q == WAIT);
    assign timed_out = (cnt_q == 16'(TIMEOUT_CYCLES));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state decode; a finish edge beats a simultaneous timeout.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (enable_i && win_found) state_d = SETUP;
            SETUP:   if (cnt_q == 16'(SETTLE_CYCLES - 1)) state_d = START;
            START:   if (cnt_q == 16'(START_CYCLES - 1)) state_d = WAIT;
            WAIT:    if (fin_rise || timed_out) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Two-flop synchronizer plus edge-history flop for the async finish.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fin_s1_q   <= 1'b0;
            fin_s2_q   <= 1'b0;
            fin_hist_q <= 1'b0;
        end else begin
            fin_s1_q   <= adc_conversion_finished_i;
            fin_s2_q   <= fin_s1_q;
            fin_hist_q <= fin_s2_q;
        end
    end

    // Transaction datapath: phase counter, grant, config, result, pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            gnt_q        <= '0;
            gidx_q       <= '0;
            last_grant_q <= IDXW'(NREQ - 1);
            cfg1_q       <= '0;
            cfg2_q       <= '0;
            result_q     <= '0;
            ok_q         <= 1'b0;
            start_q      <= 1'b0;
        end else begin
            // Counter restarts on every state change and saturates.
            if (state_q == IDLE || state_d != state_q) cnt_q <= '0;
            else if (cnt_q != 16'hFFFF)                cnt_q <= cnt_q + 16'd1;

            start_q <= (state_d == START);

            if (state_q == IDLE && state_d == SETUP) begin
                gidx_q <= win_idx;
                gnt_q  <= NREQ'(1) << win_idx;
                cfg1_q <= cfg1_arr[win_idx];
                cfg2_q <= cfg2_arr[win_idx];
            end

            if (state_q == WAIT && state_d == DONE) begin
                ok_q <= fin_rise;
                if (fin_rise) result_q <= adc_result_i;
            end

            if (state_q == DONE) begin
                last_grant_q <= gidx_q;
                gnt_q        <= '0;
            end
        end
    end

    assign gnt_o                  = gnt_q;
    assign done_o                 = (state_q == DONE &&  ok_q) ? gnt_q : '0;
    assign timeout_o              = (state_q == DONE && !ok_q) ? gnt_q : '0;
    assign result_o               = result_q;
    assign busy_o                 = (state_q != IDLE);
    assign adc_start_conversion_o = start_q;
    assign adc_config_1_o         = cfg1_q;
    assign adc_config_2_o         = cfg2_q;

endmodule
